// File: rtl/noc_input_unit_if.sv
// noc_input_unit_if: upstream flit handshake, arbiter request/grant and downstream flit bundle
interface noc_input_unit_if #(
    parameter int N      = 5,
    parameter int FLIT_W = 32
);
    logic              in_valid;
    logic [FLIT_W-1:0] in_flit;
    logic              in_ready;
    logic [N-1:0]      req;
    logic              grant;
    logic              out_valid;
    logic [FLIT_W-1:0] out_flit;
    logic              busy;
    logic              err_drop;
    modport master (
        output in_valid, in_flit, grant,
        input  in_ready, req, out_valid, out_flit, busy, err_drop
    );
    modport slave (
        input  in_valid, in_flit, grant,
        output in_ready, req, out_valid, out_flit, busy, err_drop
    );
endinterface

// File: rtl/noc_input_unit.sv
// noc_input_unit: flit FIFO, XY route compute and wormhole request FSM for one router input port
module noc_input_unit #(
    parameter int N       = 5,
    parameter int DEPTH   = 4,
    parameter int FLIT_W  = 32,
    parameter int COORD_W = 3,
    parameter int CUR_X   = 0,
    parameter int CUR_Y   = 0
) (
    input logic            clk,
    input logic            rst_n,
    noc_input_unit_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(N);
    localparam logic [COORD_W-1:0] CX = COORD_W'(CUR_X);
    localparam logic [COORD_W-1:0] CY = COORD_W'(CUR_Y);
    typedef enum logic {IDLE, ACTIVE} state_e;
    state_e            state_q, state_d;
    logic [FLIT_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [PW-1:0]     route_q, route_d, route_c;
    logic [FLIT_W-1:0] head;
    logic [COORD_W-1:0] dx, dy;
    logic              empty, is_head, is_tail, push, pop, xfer, drop;

    assign head    = mem_q[rd_ptr_q];
    assign dx      = head[COORD_W-1:0];
    assign dy      = head[2*COORD_W-1:COORD_W];
    assign is_head = head[FLIT_W-2];
    assign is_tail = head[FLIT_W-1];
    assign empty   = count_q == '0;
    // port index: 0 local, 1 east, 2 west, 3 north, 4 south
    assign route_c = dx > CX ? PW'(1) : dx < CX ? PW'(2) : dy > CY ? PW'(3) : dy < CY ? PW'(4) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q == IDLE ? ((!empty && is_head) ? ACTIVE : IDLE)
                                  : ((xfer && is_tail) ? IDLE : ACTIVE);
    end

    always_comb begin
        bus.req       = (state_q == ACTIVE && !empty) ? N'(1) << route_q : '0;
        xfer          = |bus.req && bus.grant;
        drop          = state_q == IDLE && !empty && !is_head;
        bus.out_valid = xfer;
        bus.out_flit  = xfer ? head : '0;
        bus.busy      = state_q == ACTIVE;
        bus.err_drop  = drop;
        bus.in_ready  = count_q < CW'(DEPTH);
    end

    always_comb begin
        push     = bus.in_valid && bus.in_ready;
        pop      = xfer || drop;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        count_d  = count_q + CW'(push) - CW'(pop);
        route_d  = (state_q == IDLE && state_d == ACTIVE) ? route_c : route_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            route_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            route_q  <= route_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= bus.in_flit;
    end
endmodule

// File: tb/tb_noc_input_unit.sv
// tb_noc_input_unit: scenario tasks plus a queue-based packet model of the input unit
module tb_noc_input_unit;
    localparam int N = 5, DEPTH = 4, FLIT_W = 32, COORD_W = 3, CX = 1, CY = 1;
    logic clk = 0, rst_n = 1;
    always #5 clk = ~clk;

    noc_input_unit_if #(.N(N), .FLIT_W(FLIT_W)) bus ();
    noc_input_unit #(.N(N), .DEPTH(DEPTH), .FLIT_W(FLIT_W), .COORD_W(COORD_W), .CUR_X(CX), .CUR_Y(CY))
        dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int errors = 0, checks = 0;
    logic [FLIT_W-1:0] mq[$];
    bit mact = 0;
    int mroute = 0;

    function automatic logic [FLIT_W-1:0] mk(input logic [1:0] t, input int x, input int y);
        mk = {t, 24'($urandom), 3'(y), 3'(x)};
    endfunction
    function automatic int route_of(input logic [FLIT_W-1:0] f);
        int dx = int'(f[2:0]), dy = int'(f[5:3]);
        if (dx > CX) return 1;
        if (dx < CX) return 2;
        if (dy > CY) return 3;
        if (dy < CY) return 4;
        return 0;
    endfunction
    function automatic bit is_head(input logic [FLIT_W-1:0] f); return f[31:30] == 2'b01 || f[31:30] == 2'b11; endfunction
    function automatic bit is_tail(input logic [FLIT_W-1:0] f); return f[31:30] == 2'b10 || f[31:30] == 2'b11; endfunction
    function automatic logic [N-1:0] e_req(); return (mact && mq.size() > 0) ? N'(1 << mroute) : '0; endfunction
    function automatic logic e_ov(); return e_req() != 0 && bus.grant; endfunction
    function automatic logic [FLIT_W-1:0] e_flit(); return e_ov() ? mq[0] : '0; endfunction
    function automatic logic e_ready(); return mq.size() < DEPTH; endfunction
    function automatic logic e_drop(); return !mact && mq.size() > 0 && !is_head(mq[0]); endfunction

    // advance one clock edge, updating the model from the inputs seen before it
    task automatic tick();
        bit push, pop, dr;
        logic [FLIT_W-1:0] f;
        push = bus.in_valid && mq.size() < DEPTH;
        f = bus.in_flit;
        pop = e_ov();
        dr = e_drop();
        if (!mact && mq.size() > 0 && is_head(mq[0])) begin mact = 1; mroute = route_of(mq[0]); end
        else if (pop && is_tail(mq[0])) mact = 0;
        @(posedge clk);
        if (pop || dr) void'(mq.pop_front());
        if (push) mq.push_back(f);
        @(negedge clk);
    endtask

    task automatic test_reset();
        #2 rst_n = 0;
        #1;
        checks++; if (bus.req !== 5'b0) begin errors++; $display("FAIL reset_req: got %b exp 00000", bus.req); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b exp 0", bus.out_valid); end
        checks++; if (bus.out_flit !== '0) begin errors++; $display("FAIL reset_out_flit: got %h exp 0", bus.out_flit); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b exp 1", bus.in_ready); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", bus.busy); end
        checks++; if (bus.err_drop !== 1'b0) begin errors++; $display("FAIL reset_err_drop: got %b exp 0", bus.err_drop); end
        @(negedge clk);
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (bus.req !== 5'b0) begin errors++; $display("FAIL idle_req: got %b exp 00000", bus.req); end
            tick();
        end
    endtask

    task automatic test_route(input int x, input int y, input logic [N-1:0] exp_req);
        logic [FLIT_W-1:0] f = mk(2'b11, x, y);
        bus.in_valid = 1; bus.in_flit = f; bus.grant = 1;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL route_ready: got %b exp 1", bus.in_ready); end
        tick();
        bus.in_valid = 0;
        #1;
        checks++; if (bus.req !== 5'b0) begin errors++; $display("FAIL route_req_early (%0d,%0d): got %b exp 00000", x, y, bus.req); end
        tick();
        #1;
        checks++; if (bus.req !== exp_req || bus.req !== e_req()) begin errors++; $display("FAIL route_req (%0d,%0d): got %b exp %b", x, y, bus.req, exp_req); end
        checks++; if (bus.out_valid !== 1'b1 || bus.out_flit !== f) begin errors++; $display("FAIL route_out (%0d,%0d): got %b/%h exp 1/%h", x, y, bus.out_valid, bus.out_flit, f); end
        tick();
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL route_done (%0d,%0d): got busy=%b ov=%b exp 0/0", x, y, bus.busy, bus.out_valid); end
        bus.grant = 0;
        tick();
    endtask

    task automatic test_wormhole();
        logic [FLIT_W-1:0] f[4];
        bit g[5] = '{1, 0, 1, 1, 1};
        int pulses = 0;
        f[0] = mk(2'b01, 1, 3); f[1] = mk(2'b00, 5, 5); f[2] = mk(2'b00, 6, 2); f[3] = mk(2'b10, 7, 0);
        bus.grant = 0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1; bus.in_flit = f[i];
            #1;
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL worm_ready %0d: got %b exp 1", i, bus.in_ready); end
            tick();
        end
        bus.in_valid = 0;
        for (int i = 0; i < 5; i++) begin
            bus.grant = g[i];
            #1;
            checks++; if (bus.req !== 5'b01000) begin errors++; $display("FAIL worm_req %0d: got %b exp 01000", i, bus.req); end
            checks++; if (bus.out_valid !== e_ov()) begin errors++; $display("FAIL worm_ov %0d: got %b exp %b", i, bus.out_valid, e_ov()); end
            if (bus.out_valid === 1'b1 && pulses < 4) begin
                checks++; if (bus.out_flit !== f[pulses]) begin errors++; $display("FAIL worm_flit %0d: got %h exp %h", pulses, bus.out_flit, f[pulses]); end
            end
            if (bus.out_valid === 1'b1) pulses++;
            tick();
        end
        bus.grant = 0;
        #1;
        checks++; if (pulses != 4) begin errors++; $display("FAIL worm_pulses: got %0d exp 4", pulses); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL worm_busy: got %b exp 0", bus.busy); end
        tick();
    endtask

    task automatic test_full();
        logic [FLIT_W-1:0] f[6], exp_q[$];
        f[0] = mk(2'b01, 3, 1);
        for (int i = 1; i < 5; i++) f[i] = mk(2'b00, i, i);
        f[5] = mk(2'b10, 2, 6);
        bus.grant = 0;
        for (int i = 0; i < 4; i++) begin
            bus.in_valid = 1; bus.in_flit = f[i];
            #1;
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_fill %0d: got %b exp 1", i, bus.in_ready); end
            tick();
        end
        bus.in_flit = mk(2'b00, 7, 7);
        #1;
        checks++; if (bus.in_ready !== 1'b0 || bus.in_ready !== e_ready()) begin errors++; $display("FAIL full_ready: got %b exp 0", bus.in_ready); end
        checks++; if (bus.req !== 5'b00010) begin errors++; $display("FAIL full_req: got %b exp 00010", bus.req); end
        tick();
        bus.in_valid = 0; bus.grant = 1;
        #1;
        checks++; if (bus.out_valid !== 1'b1 || bus.out_flit !== f[0]) begin errors++; $display("FAIL full_pop: got %b/%h exp 1/%h", bus.out_valid, bus.out_flit, f[0]); end
        tick();
        bus.in_valid = 1; bus.in_flit = f[4];
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_reopen: got %b exp 1", bus.in_ready); end
        checks++; if (bus.out_flit !== f[1]) begin errors++; $display("FAIL full_pushpop_flit: got %h exp %h", bus.out_flit, f[1]); end
        tick();
        bus.in_flit = f[5]; bus.grant = 0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL full_pushpop_count: got %b exp 1", bus.in_ready); end
        tick();
        bus.in_valid = 0;
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL full_refill: got %b exp 0", bus.in_ready); end
        exp_q = '{f[2], f[3], f[4], f[5]};
        bus.grant = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (bus.out_valid !== 1'b1 || bus.out_flit !== exp_q[k]) begin errors++; $display("FAIL full_drain %0d: got %b/%h exp 1/%h", k, bus.out_valid, bus.out_flit, exp_q[k]); end
            tick();
        end
        #1;
        checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL full_end: got busy=%b ov=%b exp 0/0", bus.busy, bus.out_valid); end
        bus.grant = 0;
        tick();
    endtask

    task automatic test_stray();
        logic [FLIT_W-1:0] h = mk(2'b11, 2, 2);
        bus.in_valid = 1; bus.in_flit = mk(2'b00, 3, 3); bus.grant = 1;
        tick();
        bus.in_valid = 0;
        #1;
        checks++; if (bus.err_drop !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL stray_drop: got drop=%b ov=%b exp 1/0", bus.err_drop, bus.out_valid); end
        tick();
        #1;
        checks++; if (bus.err_drop !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL stray_after: got drop=%b busy=%b exp 0/0", bus.err_drop, bus.busy); end
        bus.in_valid = 1; bus.in_flit = h;
        tick();
        bus.in_valid = 0;
        tick();
        #1;
        checks++; if (bus.req !== 5'b00010 || bus.out_flit !== h) begin errors++; $display("FAIL stray_next: got %b/%h exp 00010/%h", bus.req, bus.out_flit, h); end
        tick();
        bus.grant = 0;
    endtask

    task automatic test_random();
        logic [FLIT_W-1:0] pend[$];
        int c = 0;
        for (int p = 0; p < 30; p++) begin
            int len = $urandom_range(1, 4), x = $urandom_range(0, 7), y = $urandom_range(0, 7);
            if ($urandom_range(0, 5) == 0) pend.push_back(mk(2'b00, x, y));
            if (len == 1) pend.push_back(mk(2'b11, x, y));
            else begin
                pend.push_back(mk(2'b01, x, y));
                for (int b = 0; b < len - 2; b++) pend.push_back(mk(2'b00, y, x));
                pend.push_back(mk(2'b10, y, x));
            end
        end
        while ((pend.size() > 0 || mq.size() > 0) && c < 2000) begin
            bus.in_valid = pend.size() > 0 && $urandom_range(0, 3) != 0;
            bus.in_flit = pend.size() > 0 ? pend[0] : '0;
            bus.grant = $urandom_range(0, 2) != 0;
            #1;
            checks++; if (bus.req !== e_req()) begin errors++; $display("FAIL rnd_req c=%0d: got %b exp %b", c, bus.req, e_req()); end
            checks++; if (bus.out_valid !== e_ov()) begin errors++; $display("FAIL rnd_ov c=%0d: got %b exp %b", c, bus.out_valid, e_ov()); end
            checks++; if (bus.out_flit !== e_flit()) begin errors++; $display("FAIL rnd_flit c=%0d: got %h exp %h", c, bus.out_flit, e_flit()); end
            checks++; if (bus.in_ready !== e_ready()) begin errors++; $display("FAIL rnd_ready c=%0d: got %b exp %b", c, bus.in_ready, e_ready()); end
            checks++; if (bus.busy !== mact) begin errors++; $display("FAIL rnd_busy c=%0d: got %b exp %b", c, bus.busy, mact); end
            checks++; if (bus.err_drop !== e_drop()) begin errors++; $display("FAIL rnd_drop c=%0d: got %b exp %b", c, bus.err_drop, e_drop()); end
            if (bus.in_valid && mq.size() < DEPTH) void'(pend.pop_front());
            tick();
            c++;
        end
        bus.in_valid = 0; bus.grant = 0;
        #1;
        checks++; if (c >= 2000) begin errors++; $display("FAIL rnd_budget: got %0d cycles exp <2000", c); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rnd_end_busy: got %b exp 0", bus.busy); end
        tick();
    endtask

    task automatic test_reset_mid();
        bus.grant = 0;
        bus.in_valid = 1; bus.in_flit = mk(2'b01, 0, 1);
        tick();
        bus.in_flit = mk(2'b00, 4, 4);
        tick();
        bus.in_valid = 0;
        #2 rst_n = 0;
        mq.delete(); mact = 0;
        #1;
        checks++; if (bus.req !== 5'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_req_ready: got %b/%b exp 00000/1", bus.req, bus.in_ready); end
        checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got busy=%b ov=%b exp 0/0", bus.busy, bus.out_valid); end
        @(negedge clk);
        rst_n = 1; bus.grant = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL rstmid_after %0d: got ov=%b rdy=%b exp 0/1", i, bus.out_valid, bus.in_ready); end
            tick();
        end
        bus.grant = 0;
    endtask

    initial begin
        bus.in_valid = 0; bus.in_flit = '0; bus.grant = 0;
        test_reset();
        test_route(3, 1, 5'b00010);
        test_route(0, 2, 5'b00100);
        test_route(1, 0, 5'b10000);
        test_route(1, 1, 5'b00001);
        test_wormhole();
        test_full();
        test_stray();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
